// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and the character type.
package uart_pkg;

  localparam int DEF_CHAR_W = 8;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef logic [DEF_CHAR_W-1:0] char_t;

endpackage

// File: rtl/char_fifo_mem.sv
// DEPTH x CHAR_W register array: one synchronous write port, one asynchronous read port.
module char_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int CHAR_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [CHAR_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [CHAR_W-1:0]        o_rdata
);

  logic [CHAR_W-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; emptiness is tracked by the owner's count.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/char_fifo.sv
// Receive-side character FIFO between the UART receiver and its consumer.
// Optional LF line detection is enabled by defining CHAR_FIFO_LINE_DET_EN.
module char_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CHAR_W = DEF_CHAR_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CHAR_W-1:0]      i_char,
  input  logic                   i_finished,
  output logic [CHAR_W-1:0]      o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overflow,
  input  logic                   i_ovf_clr
`ifdef CHAR_FIFO_LINE_DET_EN
  ,
  output logic                   o_line_ready
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_push;
  logic w_pop;
  logic w_drop;

  // Handshake: a byte transfers on any edge where o_valid && i_ready; o_data is
  // the head byte and stays stable until that transfer. i_ready while empty is ignored.
  assign w_pop  = o_valid && i_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
  assign w_push = i_finished && (!o_full || w_pop);
  assign w_drop = i_finished && !w_push;

  char_fifo_mem #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_char),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A drop and a clear in the same cycle leave the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_count    = r_count;
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_valid    = !o_empty;
  assign o_overflow = r_overflow;

`ifdef CHAR_FIFO_LINE_DET_EN
  logic [CW-1:0] r_line_cnt;
  logic          w_push_lf;
  logic          w_pop_lf;

  // Only accepted LFs are counted; a dropped LF never entered the buffer.
  assign w_push_lf = w_push && (i_char == CHAR_W'(ASCII_LF));
  assign w_pop_lf  = w_pop && (o_data == CHAR_W'(ASCII_LF));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_cnt <= '0;
    end else begin
      case ({w_push_lf, w_pop_lf})
        2'b10:   r_line_cnt <= r_line_cnt + CW'(1);
        2'b01:   r_line_cnt <= r_line_cnt - CW'(1);
        default: r_line_cnt <= r_line_cnt;
      endcase
    end
  end

  assign o_line_ready = (r_line_cnt != '0);
`endif

endmodule

// File: tb/tb_char_fifo.sv
// Bench for char_fifo: vector table, directed corner sequences, random run against a queue model.
module tb_char_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] ch;
  logic       fin;
  logic [7:0] data;
  logic       valid;
  logic       rdy;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       clr;
`ifdef CHAR_FIFO_LINE_DET_EN
  logic       line_ready;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  char_fifo #(.DEPTH(DEPTH), .CHAR_W(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_char     (ch),
    .i_finished (fin),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (rdy),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (ovf),
`ifdef CHAR_FIFO_LINE_DET_EN
    .o_line_ready (line_ready),
`endif
    .i_ovf_clr  (clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic f, input logic [7:0] c,
                       input logic rd, input logic cl);
    rst = r; fin = f; ch = c; rdy = rd; clr = cl;
  endtask

  // Apply inputs for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic r, input logic f, input logic [7:0] c,
                     input logic rd, input logic cl);
    drive(r, f, c, rd, cl);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Checks every status output given the expected count, flag and head byte.
  task automatic check_state(input string name, input int e_cnt, input logic e_ovf,
                             input logic [7:0] e_head);
    check({name, ".count"}, 32'(count), 32'(e_cnt));
    check({name, ".valid"}, 32'(valid), 32'(e_cnt != 0));
    check({name, ".empty"}, 32'(empty), 32'(e_cnt == 0));
    check({name, ".full"},  32'(full),  32'(e_cnt == DEPTH));
    check({name, ".ovf"},   32'(ovf),   32'(e_ovf));
    if (e_cnt != 0) check({name, ".data"}, 32'(data), 32'(e_head));
  endtask

  // ---------------- reference model ----------------
  task automatic model_step(input logic r, input logic f, input logic [7:0] c,
                            input logic rd, input logic cl);
    bit do_pop, do_push;
    if (r) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      return;
    end
    do_pop  = (exp_q.size() > 0) && rd;
    do_push = f && ((exp_q.size() < DEPTH) || do_pop);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(c);
    if (f && !do_push) exp_ovf = 1'b1;
    else if (cl) exp_ovf = 1'b0;
  endtask

  function automatic int lf_in_model();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == 8'h0A) n++;
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       fin;
    logic [7:0] ch;
    logic       rdy;
    logic       clr;
    int         e_cnt;
    logic       e_ovf;
    logic [7:0] e_head;
  } vec_t;

  vec_t vecs[9];

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_ovf = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 1'b0, 8'h00);
`ifdef CHAR_FIFO_LINE_DET_EN
    check("reset.line_ready", 32'(line_ready), 32'd0);
`endif

    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 8'h41};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 8'h42, 1'b1, 1'b0, 1, 1'b0, 8'h42};
    vecs[4] = '{1'b1, 8'h43, 1'b1, 1'b0, 1, 1'b0, 8'h43};
    vecs[5] = '{1'b1, 8'h44, 1'b0, 1'b0, 2, 1'b0, 8'h43};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b0, 8'h43};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h44};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};

    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, vecs[i].fin, vecs[i].ch, vecs[i].rdy, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_head);
    end

    // Fill to full with 00..0F.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    check_state("fill", DEPTH, 1'b0, 8'h00);

    // Push into full without pop: dropped, flag set.
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    check_state("drop", DEPTH, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_state("ovf_clr", DEPTH, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
    check_state("set_wins", DEPTH, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_state("ovf_clr2", DEPTH, 1'b0, 8'h00);

    // Push and pop together while full: accepted, count unchanged.
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    check_state("full_pushpop", DEPTH, 1'b0, 8'h01);

    // Drain: 01..0F then 55, one per cycle.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain%0d.data", i), 32'(data), (i < DEPTH) ? 32'(i) : 32'h55);
      check($sformatf("drain%0d.valid", i), 32'(valid), 32'd1);
      @(posedge clk);
      #1;
    end
    check_state("drained", 0, 1'b0, 8'h00);

    // Reset with 5 held and a same-cycle push.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check_state("five", 5, 1'b0, 8'h60);
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    check_state("rst_mid", 0, 1'b0, 8'h00);

`ifdef CHAR_FIFO_LINE_DET_EN
    cyc(1'b0, 1'b1, 8'h4F, 1'b0, 1'b0);
    check("lr_O", 32'(line_ready), 32'd0);
    cyc(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0);
    check("lr_K", 32'(line_ready), 32'd0);
    cyc(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
    check("lr_LF", 32'(line_ready), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("lr_popO", 32'(line_ready), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("lr_popK", 32'(line_ready), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("lr_popLF", 32'(line_ready), 32'd0);
    check_state("lr_empty", 0, 1'b0, 8'h00);
`endif

    // Randomized run against the queue model.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic r, f, rd, cl;
      logic [7:0] c;
      int rdy_pct;
      rdy_pct = ((n / 250) % 3 == 0) ? 15 : (((n / 250) % 3 == 1) ? 50 : 85);
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < rdy_pct);
      cl = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      model_step(r, f, c, rd, cl);
      cyc(r, f, c, rd, cl);
      check_state($sformatf("rnd%0d", n), exp_q.size(), exp_ovf,
                  (exp_q.size() > 0) ? exp_q[0] : 8'h00);
`ifdef CHAR_FIFO_LINE_DET_EN
      check($sformatf("rnd%0d.line_ready", n), 32'(line_ready), 32'(lf_in_model() != 0));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/char_fifo.md
Name: char_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART character receiver.
- Captures each received character on the receiver's one-cycle done pulse and holds it in a DEPTH-entry circular FIFO.
- Presents the held bytes to the consumer (command parser / bus bridge) over a valid/ready handshake.
- Absorbs bursts so the consumer may stall without losing characters; any loss is flagged.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, minimum 2.
- CHAR_W, 8, character width in bits.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_char  input  CHAR_W  received character from the receiver.
- i_finished  input  1  one-cycle pulse; i_char is valid in this cycle.
- o_data  output  CHAR_W  head-of-FIFO byte; meaningful only while o_valid=1.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_count  output  $clog2(DEPTH)+1  number of entries currently held.
- o_full  output  1  o_count==DEPTH.
- o_empty  output  1  o_count==0.
- o_overflow  output  1  sticky flag: a character was dropped.
- i_ovf_clr  input  1  clears o_overflow.
- o_line_ready  output  1  only when LINE_DET_EN is defined: at least one LF byte is held.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - wr_ptr=rd_ptr=0, count=0, o_overflow=0, line counter=0.
  - Outputs: o_valid=0, o_empty=1, o_full=0, o_count=0, o_line_ready=0.
  - o_data is don't-care. Storage contents are not cleared.
  - Reset mid-operation discards all held bytes, and the reset takes priority over a same-cycle push, pop or clear.
- Push: i_finished=1 and not full.
  - mem[wr_ptr] <= i_char; wr_ptr advances by 1 and wraps modulo DEPTH.
- Pop: o_valid && i_ready.
  - rd_ptr advances by 1, wrapping modulo DEPTH.
  - i_ready while empty has no effect.
- Show-ahead read: o_data = mem[rd_ptr] combinationally from the registered pointer. No read latency.
- Write-to-read latency is 1 cycle: a push at edge N gives o_valid=1 and o_data=that byte after edge N. There is no same-cycle bypass when empty.
- Count update: +1 on push only; -1 on pop only; unchanged on push+pop or on neither.
- Simultaneous push and pop while full:
  - The pop frees a slot, so the push is accepted.
  - Count stays DEPTH; no overflow.
- Push while full without pop:
  - The byte is dropped; pointers and count are unchanged.
  - o_overflow <= 1 at the next edge.
- Overflow flag:
  - o_overflow stays set until i_ovf_clr=1.
  - If a set and a clear occur in the same cycle, the set wins.
- o_full, o_empty and o_valid are decoded from the registered count, with no extra flop stages.
- All pointer and count arithmetic is unsigned and wraps naturally; the pointer width is $clog2(DEPTH).

Optional Feature:
- Macro: CHAR_FIFO_LINE_DET_EN.
- Defined:
  - A line counter (width $clog2(DEPTH)+1) increments on an accepted push of 8'h0A and decrements on a pop of 8'h0A.
  - Both in one cycle: unchanged.
  - o_line_ready = (line counter != 0).
  - A dropped LF does not count.
- Undefined: the o_line_ready port and the counter do not exist.

Decomposition:
- Package uart_pkg:
  - CHAR_W default constant.
  - ASCII_LF = 8'h0A and ASCII_CR = 8'h0D.
  - typedef logic [CHAR_W-1:0] char_t.
- Sub-module char_fifo_mem:
  - DEPTH x CHAR_W register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- char_fifo holds the pointers, count, flags and optional line detection.

Test Plan:
- Reset then push 8'h41 with i_ready=0: o_valid=1 and o_data=8'h41 one cycle later, o_count=1. Raise i_ready one cycle: o_empty=1 and o_count=0 after that edge.
- Push 16 bytes 8'h00..8'h0F (DEPTH=16) with no pop: o_full=1 and o_count=16. Then drain with i_ready held high: outputs 8'h00..8'h0F in order, one per cycle, then o_valid=0.
- Fill to 16, push 8'hAA without pop: o_overflow=1, o_count=16, head still 8'h00. Pulse i_ovf_clr: o_overflow=0 next cycle.
- Full FIFO with push 8'h55 and pop in the same cycle: o_count stays 16, o_overflow=0, and 8'h55 is emitted as the 16th byte afterwards (wrap-around check).
- Reset asserted while o_count=5 and a push is in the same cycle: next cycle o_count=0, o_valid=0, o_overflow=0.
- With CHAR_FIFO_LINE_DET_EN: push "O","K",8'h0A. o_line_ready=1 after the third push; it stays 1 until the 8'h0A is popped, then returns to 0.
